// File: rtl/switch_input_pkg.sv
`default_nettype none
// ============================================================================
// Module      : switch_input_pkg
// Description : Shared constants for the switch input controller: register
//               byte offsets inside the I/O block and the CPU data width.
// Revision    : 1.0 - initial release
// ============================================================================
package switch_input_pkg;

    // CPU data path width
    localparam int SWI_DW = 16;

    // Register byte offsets (16-bit halves)
    localparam logic [3:0] SWI_DATA_LO = 4'h0;
    localparam logic [3:0] SWI_DATA_HI = 4'h2;
    localparam logic [3:0] SWI_CHG_LO  = 4'h4;
    localparam logic [3:0] SWI_CHG_HI  = 4'h6;
    localparam logic [3:0] SWI_IEN_LO  = 4'h8;
    localparam logic [3:0] SWI_IEN_HI  = 4'hA;

endpackage
`default_nettype wire

// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : switch_debouncer
// Description : Two-flop synchroniser, sample prescaler and per-bit history
//               debouncer for a bank of raw switch inputs.
// Ports       : clock_i/reset_i   - clock, asynchronous active-high reset
//               raw_i             - raw asynchronous switch levels
//               deb_o             - debounced switch vector
//               rise_o / fall_o   - one-cycle pulse per bit on an accepted
//                                   debounced transition (after init only)
//               init_done_o       - first full-history load has happened
// Revision    : 1.0 - initial release
// ============================================================================
module switch_debouncer #(
    parameter int SW_WIDTH       = 24,
    parameter int SAMPLE_DIV     = 50000,
    parameter int STABLE_SAMPLES = 3
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic [SW_WIDTH-1:0] raw_i,
    output logic [SW_WIDTH-1:0] deb_o,
    output logic [SW_WIDTH-1:0] rise_o,
    output logic [SW_WIDTH-1:0] fall_o,
    output logic                init_done_o
);

    localparam int CNT_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int FILL_W = $clog2(STABLE_SAMPLES + 1);

    logic [SW_WIDTH-1:0] sync1_q;
    logic [SW_WIDTH-1:0] sync2_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sample_tick;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic                init_q, init_d;
    logic                load;
    logic [SW_WIDTH-1:0] deb_q, deb_d;
    logic [SW_WIDTH-1:0] rise, fall;

    // Only STABLE_SAMPLES-1 past samples are stored; the incoming synchronised
    // sample completes the window, so the decision lands on the same tick.
    logic [SW_WIDTH-1:0][STABLE_SAMPLES-2:0] hist_q, hist_d;

    assign sample_tick = (cnt_q == CNT_W'(SAMPLE_DIV - 1));
    assign cnt_d       = sample_tick ? '0 : cnt_q + CNT_W'(1);

    // The window becomes full on the STABLE_SAMPLES-th tick after reset.
    assign load   = sample_tick && !init_q && (fill_q == FILL_W'(STABLE_SAMPLES - 1));
    assign init_d = init_q | load;
    assign fill_d = (sample_tick && !init_q) ? fill_q + FILL_W'(1) : fill_q;

    for (genvar i = 0; i < SW_WIDTH; i++) begin : g_bit
        logic [STABLE_SAMPLES-1:0] win;
        assign win       = {hist_q[i], sync2_q[i]};
        assign hist_d[i] = sample_tick ? win[STABLE_SAMPLES-2:0] : hist_q[i];
        assign rise[i]   = sample_tick && init_q && (&win)  && !deb_q[i];
        assign fall[i]   = sample_tick && init_q && !(|win) &&  deb_q[i];
    end

    assign deb_d = load ? sync2_q : ((deb_q | rise) & ~fall);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cnt_q   <= '0;
            fill_q  <= '0;
            init_q  <= 1'b0;
            deb_q   <= '0;
            hist_q  <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            init_q  <= init_d;
            deb_q   <= deb_d;
            hist_q  <= hist_d;
        end
    end

    assign deb_o       = deb_q;
    assign rise_o      = rise;
    assign fall_o      = fall;
    assign init_done_o = init_q;

endmodule
`default_nettype wire

// File: rtl/switch_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : switch_input_ctrl
// Description : Memory-mapped switch input controller. Debounced switch data,
//               sticky W1C change flags, interrupt enable mask and a
//               registered level interrupt request.
// Ports       : clock/reset       - clock, asynchronous active-high reset
//               Select            - I/O chip select
//               Read_enable       - CPU read strobe
//               Write_enable      - CPU write strobe
//               Address           - byte offset within the block
//               Write_data_in     - CPU write data
//               Read_data_in      - raw switch levels
//               Read_data_out     - registered read data (1-cycle latency)
//               irq               - |(chg & ien), registered
// Revision    : 1.0 - initial release
// ============================================================================
module switch_input_ctrl
    import switch_input_pkg::*;
#(
    parameter int SW_WIDTH       = 24,
    parameter int SAMPLE_DIV     = 50000,
    parameter int STABLE_SAMPLES = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                Select,
    input  logic                Read_enable,
    input  logic                Write_enable,
    input  logic [3:0]          Address,
    input  logic [SWI_DW-1:0]   Write_data_in,
    input  logic [SW_WIDTH-1:0] Read_data_in,
    output logic [SWI_DW-1:0]   Read_data_out,
    output logic                irq
);

    logic [SW_WIDTH-1:0] deb;
    logic [SW_WIDTH-1:0] rise, fall;
    logic                init_done;

    logic [SW_WIDTH-1:0] chg_q, chg_d;
    logic [SW_WIDTH-1:0] ien_q, ien_d;
    logic [SWI_DW-1:0]   rdata_q, rdata_d;
    logic                irq_q, irq_d;

    logic                wr;
    logic [SW_WIDTH-1:0] chg_clr;
    logic [SW_WIDTH-1:0] ien_wr;
    logic [SW_WIDTH-1:0] ien_val;
    logic [SW_WIDTH-1:0] chg_set;

    logic [31:0] data_ext, chg_ext, ien_ext;

    switch_debouncer #(
        .SW_WIDTH       (SW_WIDTH),
        .SAMPLE_DIV     (SAMPLE_DIV),
        .STABLE_SAMPLES (STABLE_SAMPLES)
    ) u_deb (
        .clock_i     (clock),
        .reset_i     (reset),
        .raw_i       (Read_data_in),
        .deb_o       (deb),
        .rise_o      (rise),
        .fall_o      (fall),
        .init_done_o (init_done)
    );

    assign wr = Select && Write_enable;

    // Per-bit write decode: bits 0..15 live in the low half-register,
    // bits 16..31 in the high one.
    for (genvar i = 0; i < SW_WIDTH; i++) begin : g_wr
        localparam logic [3:0] C_CHG_OFS = (i < 16) ? SWI_CHG_LO : SWI_CHG_HI;
        localparam logic [3:0] C_IEN_OFS = (i < 16) ? SWI_IEN_LO : SWI_IEN_HI;
        assign chg_clr[i] = wr && (Address == C_CHG_OFS) && Write_data_in[i % 16];
        assign ien_wr[i]  = wr && (Address == C_IEN_OFS);
        assign ien_val[i] = Write_data_in[i % 16];
    end

    // A transition arriving in the same cycle as a clear keeps the flag set.
    assign chg_set = (rise | fall) & {SW_WIDTH{init_done}};
    assign chg_d   = (chg_q & ~chg_clr) | chg_set;
    assign ien_d   = (ien_q & ~ien_wr) | (ien_val & ien_wr);
    assign irq_d   = |(chg_q & ien_q);

    assign data_ext = 32'(deb);
    assign chg_ext  = 32'(chg_q);
    assign ien_ext  = 32'(ien_q);

    // Read mux uses pre-write state, so a simultaneous write is not visible.
    always_comb begin
        rdata_d = '0;
        if (Select && Read_enable) begin
            case (Address)
                SWI_DATA_LO: rdata_d = data_ext[15:0];
                SWI_DATA_HI: rdata_d = data_ext[31:16];
                SWI_CHG_LO:  rdata_d = chg_ext[15:0];
                SWI_CHG_HI:  rdata_d = chg_ext[31:16];
                SWI_IEN_LO:  rdata_d = ien_ext[15:0];
                SWI_IEN_HI:  rdata_d = ien_ext[31:16];
                default:     rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            chg_q   <= '0;
            ien_q   <= '0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            chg_q   <= chg_d;
            ien_q   <= ien_d;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
        end
    end

    assign Read_data_out = rdata_q;
    assign irq           = irq_q;

endmodule
`default_nettype wire
